// File: rtl/seq_divider_param_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_param_pkg;

    // Controller states: waiting for a request, or stepping the divide.
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Widest supported divisor/quotient width.
    localparam int MAX_DW = 32;

    // Iteration counter width for a given data width: enough to hold DW-1.
    function automatic int cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // All-ones pattern in the low w bits, used as the saturated quotient.
    function automatic logic [MAX_DW-1:0] ones_fill(input int w);
        logic [MAX_DW-1:0] f;
        f = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            f[i] = (i < w);
        end
        return f;
    endfunction

endpackage

// File: rtl/seq_divider_param_trial.sv
// Combinational W-bit trial subtract: diff = a - b, neg flags a < b.
module div_trial_sub #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         neg
);

    // Operands are kept one bit wider than the data, so the MSB of the
    // wrapped difference is the borrow.
    always_comb begin
        diff = a - b;
        neg  = diff[W-1];
    end

endmodule

// File: rtl/seq_divider_param.sv
// Self-sequenced restoring divider: 2*DW-bit dividend / DW-bit divisor,
// DW-bit quotient and remainder, divide-by-zero and overflow pre-checks.
module seq_divider_param
    import seq_divider_param_pkg::*;
#(
    parameter int DW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int                CW        = cnt_width(DW);
    localparam logic [MAX_DW-1:0] ONES_FULL = ones_fill(DW);
    localparam logic [DW-1:0]     Q_ONES    = ONES_FULL[DW-1:0];
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DW - 1);

    state_t        state, state_nxt;
    // Partial remainder. The overflow pre-check keeps it below the divisor,
    // so its conceptual top bit is always zero between steps and is not stored.
    logic [DW-1:0] r;
    logic [DW-1:0] q;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          is_zero;
    logic          is_ovf;
    logic          last;
    logic [DW:0]   r_sh;
    logic [DW:0]   trial_diff;
    logic          trial_neg;
    logic          trial_unused;
    logic [DW-1:0] r_nxt;
    logic [DW-1:0] q_nxt;

    assign accept  = (state == IDLE) && start;
    assign is_zero = (divisor == '0);
    assign is_ovf  = !is_zero && (dividend[2*DW-1:DW] >= divisor);
    assign last    = (cnt == CNT_LAST);
    assign busy    = (state == CALC);

    // One restoring step: shift {R,Q} left, then try to subtract the divisor.
    assign r_sh = {r, q[DW-1]};

    div_trial_sub #(.W(DW + 1)) u_trial (
        .a    (r_sh),
        .b    ({1'b0, d}),
        .diff (trial_diff),
        .neg  (trial_neg)
    );

    // A successful trial leaves a result below the divisor, so its top bit is zero.
    assign trial_unused = trial_diff[DW];
    assign r_nxt = trial_neg ? r_sh[DW-1:0] : trial_diff[DW-1:0];
    assign q_nxt = {q[DW-2:0], ~trial_neg};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: error cases complete without leaving IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && !is_zero && !is_ovf) state_nxt = CALC;
            CALC: if (last)                          state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // Datapath, result registers and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (is_zero) begin
                            div_by_zero <= 1'b1;
                            quotient    <= Q_ONES;
                            remainder   <= dividend[DW-1:0];
                            done        <= 1'b1;
                        end else if (is_ovf) begin
                            overflow    <= 1'b1;
                            quotient    <= Q_ONES;
                            remainder   <= '0;
                            done        <= 1'b1;
                        end else begin
                            r   <= dividend[2*DW-1:DW];
                            q   <= dividend[DW-1:0];
                            d   <= divisor;
                            cnt <= '0;
                        end
                    end
                end
                CALC: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised, self-sequenced restoring divider: divides a 2*DW-bit unsigned dividend by a DW-bit unsigned divisor.
- Outputs a DW-bit quotient and a DW-bit remainder.
- Successor to the fixed 10/5-bit divider datapath: controller is folded in, uses a start/done handshake, returns the remainder, and flags divide-by-zero and quotient overflow before iterating.
- Sits beside the existing arithmetic blocks as a drop-in multi-cycle divide unit.

Parameters:
DW, 5, divisor/quotient/remainder width; dividend is 2*DW bits; legal range 2..32

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
dividend  in  2*DW  unsigned dividend, sampled on accepted start
divisor  in  DW  unsigned divisor, sampled on accepted start
busy  out  1  high while iterating
done  out  1  one-cycle pulse; results/flags valid from this cycle until next accepted start
quotient  out  DW  result quotient
remainder  out  DW  result remainder
div_by_zero  out  1  divisor was 0 (sticky until next accepted start)
overflow  out  1  dividend[2DW-1:DW] >= divisor, divisor != 0 (sticky until next accepted start)

Behaviour:
- Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0. Reset overrides everything, including mid-operation: the operation is abandoned and done is not produced.
- States:
  - IDLE: wait for start.
  - CALC: DW iterations.
  - Error completion goes IDLE->IDLE with a done pulse.
- Accept edge (IDLE, start=1): clear both flags.
  - If divisor==0: div_by_zero=1, quotient=all ones, remainder=dividend[DW-1:0], done=1 next cycle, stay IDLE.
  - Else if dividend[2DW-1:DW] >= divisor: overflow=1, quotient=all ones, remainder=0, done=1 next cycle, stay IDLE.
  - Else: R (DW+1 bits) <= {0, dividend[2DW-1:DW]}, Q <= dividend[DW-1:0], D <= divisor, count <= 0, busy=1, go CALC.
- CALC edge:
  - Shift {R,Q} left one bit.
  - trial = shifted R - {0,D}, computed at DW+1 bits.
  - If trial MSB=0: R <= trial and Q[0] <= 1. Else keep the shifted R and Q[0] <= 0.
  - count++.
  - On the edge where count==DW-1: go IDLE, busy=0, done=1 for the following cycle.
- Latency: done is high exactly DW+1 cycles after the accept edge's cycle (normal path). On the error paths it is high the cycle after accept.
- The pre-check guarantees the remainder is < divisor and fits in DW bits.
- quotient/remainder outputs update only at completion. During CALC they hold the previous result.
- start while busy=1 is ignored: no queueing, and the operands in flight are unaffected.
- start on the same cycle done=1 (IDLE) is accepted; done still pulses for the old result and the flags clear on that edge.
- Operand inputs are don't-care except on the accept edge.

Decomposition:
- Shared package: state enum {IDLE, CALC}; counter width constant CW = clog2(DW)+1; a helper function for the all-ones fill.
- One natural sub-module: div_trial_sub, a combinational (DW+1)-bit subtract returning difference and negative flag. It generalises the existing add/sub block.
- Controller and datapath stay in one module.

Test Plan:
- DW=5, dividend=100, divisor=7 -> after 6 cycles done=1, quotient=14, remainder=2, flags 0; busy high for 5 cycles.
- DW=5, dividend=1023, divisor=31 -> next-cycle done, overflow=1, quotient=31, remainder=0; dividend=0, divisor=9 -> quotient=0, remainder=0, no flags.
- DW=5, divisor=0, dividend=37 -> next-cycle done, div_by_zero=1, quotient=31, remainder=5; the next valid start clears div_by_zero.
- DW=8, dividend=1000, divisor=9 -> done after 9 cycles, quotient=111, remainder=1; second start issued mid-CALC is ignored and the result is unchanged.
- Assert rst on the 3rd CALC cycle of 100/7 -> next cycle all outputs 0, state IDLE, no done. A fresh start of 50/6 then gives quotient=8, remainder=2.
- Back-to-back: start held high the cycle done=1 with 200/13 -> accepted, previous result visible during the done cycle, then quotient=15, remainder=5.
